// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two-bank complex sample memory shared between the host
// loader and the in-place FFT engine. The host owns bank bank_sel, the
// engine owns the other one; ownership swaps once the host has committed a
// frame and the engine is idle.
module fft_pingpong_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic [ADDR_W:0]       host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic [2*DATA_W-1:0]   host_rdata,
  output logic                  host_rvalid,
  input  logic                  host_done,
  input  logic                  eng_rd_en,
  input  logic [ADDR_W-1:0]     eng_rd_addr,
  output logic [2*DATA_W-1:0]   eng_rd_data,
  output logic                  eng_rd_valid,
  input  logic                  eng_wr_en,
  input  logic [ADDR_W-1:0]     eng_wr_addr,
  input  logic [2*DATA_W-1:0]   eng_wr_data,
  input  logic                  eng_done,
  output logic                  eng_start,
  output logic                  bank_sel,
  output logic                  host_ready,
  output logic                  eng_busy,
  output logic [7:0]            frame_cnt,
  output logic                  err_overrun,
  output logic                  err_wrlock
);

  localparam int DEPTH = 2**ADDR_W;

  // Real and imaginary halves live in separate arrays so a host half-word
  // write never needs a read-modify-write. Index MSB is the bank.
  logic [DATA_W-1:0] mem_re [0:2*DEPTH-1];
  logic [DATA_W-1:0] mem_im [0:2*DEPTH-1];

  logic [ADDR_W:0] host_idx;
  logic [ADDR_W:0] eng_rd_idx;
  logic [ADDR_W:0] eng_wr_idx;
  logic            host_wr_ok;
  logic            host_rd_ok;
  logic            swap;

  assign host_idx   = {bank_sel, host_addr[ADDR_W:1]};
  assign eng_rd_idx = {~bank_sel, eng_rd_addr};
  assign eng_wr_idx = {~bank_sel, eng_wr_addr};
  // A committed host bank is locked until the swap hands it to the engine.
  assign host_wr_ok = host_wr & ~host_ready;
  // Any host write strobe (even a locked one) suppresses the host read.
  assign host_rd_ok = host_rd & ~host_wr;
  assign swap       = host_ready & ~eng_busy;

  // Memory writes: host and engine always target different banks.
  always_ff @(posedge clk) begin
    if (host_wr_ok) begin
      if (host_addr[0]) mem_im[host_idx] <= host_wdata;
      else              mem_re[host_idx] <= host_wdata;
    end
    if (eng_wr_en) begin
      mem_re[eng_wr_idx] <= eng_wr_data[DATA_W-1:0];
      mem_im[eng_wr_idx] <= eng_wr_data[2*DATA_W-1:DATA_W];
    end
  end

  // Registered read ports; reading before the write lands gives read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      eng_rd_data  <= '0;
      eng_rd_valid <= 1'b0;
    end else begin
      host_rvalid  <= host_rd_ok;
      eng_rd_valid <= eng_rd_en;
      if (host_rd_ok) host_rdata  <= {mem_im[host_idx], mem_re[host_idx]};
      if (eng_rd_en)  eng_rd_data <= {mem_im[eng_rd_idx], mem_re[eng_rd_idx]};
    end
  end

  // Ownership handshake, frame counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel    <= 1'b0;
      host_ready  <= 1'b0;
      eng_busy    <= 1'b0;
      eng_start   <= 1'b0;
      frame_cnt   <= 8'd0;
      err_overrun <= 1'b0;
      err_wrlock  <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (swap) begin
        bank_sel   <= ~bank_sel;
        host_ready <= 1'b0;
        eng_busy   <= 1'b1;
        eng_start  <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
      end else begin
        if (host_done && !host_ready) host_ready <= 1'b1;
        if (eng_done && eng_busy)     eng_busy   <= 1'b0;
      end
      if (host_done && host_ready) err_overrun <= 1'b1;
      if (host_wr && host_ready)   err_wrlock  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// tb_fft_pingpong_ram: directed checks of the ping-pong sample memory.
module tb_fft_pingpong_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr, host_rd;
  logic [12:0] host_addr;
  logic [15:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        host_done;
  logic        eng_rd_en;
  logic [11:0] eng_rd_addr;
  logic [31:0] eng_rd_data;
  logic        eng_rd_valid;
  logic        eng_wr_en;
  logic [11:0] eng_wr_addr;
  logic [31:0] eng_wr_data;
  logic        eng_done;
  logic        eng_start;
  logic        bank_sel;
  logic        host_ready;
  logic        eng_busy;
  logic [7:0]  frame_cnt;
  logic        err_overrun;
  logic        err_wrlock;

  int checks = 0;
  int errors = 0;

  fft_pingpong_ram #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_done(host_done),
    .eng_rd_en(eng_rd_en), .eng_rd_addr(eng_rd_addr), .eng_rd_data(eng_rd_data),
    .eng_rd_valid(eng_rd_valid),
    .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .eng_done(eng_done), .eng_start(eng_start), .bank_sel(bank_sel),
    .host_ready(host_ready), .eng_busy(eng_busy), .frame_cnt(frame_cnt),
    .err_overrun(err_overrun), .err_wrlock(err_wrlock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } hvec_t;

  hvec_t tbl [14];

  function automatic logic [12:0] ha(input int word, input logic half);
    logic [11:0] w;
    w = word[11:0];
    return {w, half};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_wr = 0; host_rd = 0; host_addr = '0; host_wdata = '0; host_done = 0;
    eng_rd_en = 0; eng_rd_addr = '0; eng_wr_en = 0; eng_wr_addr = '0;
    eng_wr_data = '0; eng_done = 0;
  endtask

  task automatic host_read(input int word);
    host_rd = 1; host_addr = ha(word, 1'b0);
    tick();
    host_rd = 0;
  endtask

  task automatic eng_read(input int word);
    eng_rd_en = 1; eng_rd_addr = word[11:0];
    tick();
    eng_rd_en = 0;
  endtask

  logic       exp_bank;
  logic [7:0] exp_cnt;

  initial begin
    // Host-port vectors applied to bank 0 right after reset.
    tbl[0]  = '{1'b1, 1'b0, ha(5, 1'b0), 16'h1234, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, ha(5, 1'b1), 16'hABCD, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 1'b1, ha(5, 1'b0), 16'h0000, 1'b1, 32'hABCD_1234};
    tbl[3]  = '{1'b0, 1'b0, ha(0, 1'b0), 16'h0000, 1'b0, 32'hABCD_1234};
    tbl[4]  = '{1'b1, 1'b1, ha(6, 1'b0), 16'h1111, 1'b0, 32'hABCD_1234};
    tbl[5]  = '{1'b1, 1'b0, ha(6, 1'b1), 16'h2222, 1'b0, 32'hABCD_1234};
    tbl[6]  = '{1'b0, 1'b1, ha(6, 1'b1), 16'h0000, 1'b1, 32'h2222_1111};
    tbl[7]  = '{1'b1, 1'b0, ha(5, 1'b0), 16'h5555, 1'b0, 32'h2222_1111};
    tbl[8]  = '{1'b0, 1'b1, ha(5, 1'b0), 16'h0000, 1'b1, 32'hABCD_5555};
    tbl[9]  = '{1'b1, 1'b0, ha(7, 1'b0), 16'h7777, 1'b0, 32'hABCD_5555};
    tbl[10] = '{1'b1, 1'b0, ha(7, 1'b1), 16'h8888, 1'b0, 32'hABCD_5555};
    tbl[11] = '{1'b0, 1'b1, ha(7, 1'b0), 16'h0000, 1'b1, 32'h8888_7777};
    tbl[12] = '{1'b1, 1'b0, ha(5, 1'b0), 16'h1234, 1'b0, 32'h8888_7777};
    tbl[13] = '{1'b0, 1'b1, ha(5, 1'b0), 16'h0000, 1'b1, 32'hABCD_1234};

    idle_inputs();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    // Reset state
    check("rst_bank_sel", {31'd0, bank_sel}, 32'd0);
    check("rst_host_ready", {31'd0, host_ready}, 32'd0);
    check("rst_eng_busy", {31'd0, eng_busy}, 32'd0);
    check("rst_eng_start", {31'd0, eng_start}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    check("rst_err_wrlock", {31'd0, err_wrlock}, 32'd0);
    check("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    check("rst_eng_rd_data", eng_rd_data, 32'd0);

    // Table-driven host writes and reads
    for (int i = 0; i < 14; i++) begin
      host_wr = tbl[i].wr; host_rd = tbl[i].rd;
      host_addr = tbl[i].addr; host_wdata = tbl[i].wdata;
      tick();
      check($sformatf("tbl%0d_rvalid", i), {31'd0, host_rvalid}, {31'd0, tbl[i].exp_rvalid});
      check($sformatf("tbl%0d_rdata", i), host_rdata, tbl[i].exp_rdata);
    end
    idle_inputs();

    // Commit and first swap
    host_done = 1;
    tick();
    host_done = 0;
    check("done_host_ready", {31'd0, host_ready}, 32'd1);
    check("done_no_swap_yet", {31'd0, bank_sel}, 32'd0);
    tick();
    check("swap1_bank_sel", {31'd0, bank_sel}, 32'd1);
    check("swap1_eng_start", {31'd0, eng_start}, 32'd1);
    check("swap1_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    check("swap1_eng_busy", {31'd0, eng_busy}, 32'd1);
    check("swap1_host_ready", {31'd0, host_ready}, 32'd0);
    tick();
    check("swap1_start_pulse_end", {31'd0, eng_start}, 32'd0);

    // Engine sees the host-loaded frame
    eng_read(5);
    check("eng_rd5_valid", {31'd0, eng_rd_valid}, 32'd1);
    check("eng_rd5_data", eng_rd_data, 32'hABCD_1234);

    // Same-cycle read/write of word 7 is read-first
    eng_rd_en = 1; eng_rd_addr = 12'd7;
    eng_wr_en = 1; eng_wr_addr = 12'd7; eng_wr_data = 32'h00FF_00FF;
    tick();
    eng_wr_en = 0; eng_rd_en = 0;
    check("eng_rw7_old", eng_rd_data, 32'h8888_7777);
    eng_read(7);
    check("eng_rd7_new", eng_rd_data, 32'h00FF_00FF);
    tick();
    check("eng_rvalid_pulse", {31'd0, eng_rd_valid}, 32'd0);

    // Overrun and write lock while the engine is busy
    host_wr = 1; host_addr = ha(5, 1'b0); host_wdata = 16'h3333;
    tick();
    host_addr = ha(5, 1'b1); host_wdata = 16'h4444;
    tick();
    host_wr = 0;
    host_done = 1;
    tick();
    check("busy_host_ready", {31'd0, host_ready}, 32'd1);
    check("busy_no_overrun", {31'd0, err_overrun}, 32'd0);
    tick();
    host_done = 0;
    check("err_overrun", {31'd0, err_overrun}, 32'd1);
    host_wr = 1; host_addr = ha(5, 1'b0); host_wdata = 16'hDEAD;
    tick();
    host_wr = 0;
    check("err_wrlock", {31'd0, err_wrlock}, 32'd1);
    host_read(5);
    check("wrlock_mem_unchanged", host_rdata, 32'h4444_3333);
    repeat (3) tick();
    check("no_swap_while_busy", {31'd0, bank_sel}, 32'd1);
    eng_done = 1;
    tick();
    eng_done = 0;
    check("eng_done_clears_busy", {31'd0, eng_busy}, 32'd0);
    check("eng_done_no_swap_yet", {31'd0, bank_sel}, 32'd1);
    tick();
    check("swap2_bank_sel", {31'd0, bank_sel}, 32'd0);
    check("swap2_eng_start", {31'd0, eng_start}, 32'd1);
    check("swap2_frame_cnt", {24'd0, frame_cnt}, 32'd2);
    check("sticky_overrun", {31'd0, err_overrun}, 32'd1);
    host_read(7);
    check("host_sees_eng_result", host_rdata, 32'h00FF_00FF);

    // Run frames until the counter wraps
    exp_bank = 1'b0;
    exp_cnt  = 8'd2;
    for (int f = 0; f < 254; f++) begin
      eng_wr_en = 1; eng_wr_addr = 12'd9; eng_wr_data = 32'hC0DE_0000 | f;
      tick();
      eng_wr_en = 0;
      if (f % 2 == 0) begin
        host_done = 1; eng_done = 1;
        tick();
        host_done = 0; eng_done = 0;
      end else begin
        host_done = 1;
        tick();
        host_done = 0;
        eng_done = 1;
        tick();
        eng_done = 0;
      end
      tick();
      exp_bank = ~exp_bank;
      exp_cnt  = exp_cnt + 8'd1;
      check($sformatf("frame%0d_bank_sel", f), {31'd0, bank_sel}, {31'd0, exp_bank});
      check($sformatf("frame%0d_eng_start", f), {31'd0, eng_start}, 32'd1);
      check($sformatf("frame%0d_frame_cnt", f), {24'd0, frame_cnt}, {24'd0, exp_cnt});
      host_read(9);
      check($sformatf("frame%0d_result", f), host_rdata, 32'hC0DE_0000 | f);
    end
    check("frame_cnt_wrapped", {24'd0, frame_cnt}, 32'd0);

    // Asynchronous reset mid-frame with a read in flight
    host_done = 1; eng_rd_en = 1; eng_rd_addr = 12'd9;
    tick();
    host_done = 0; eng_rd_en = 0;
    check("pre_rst_ready", {31'd0, host_ready}, 32'd1);
    check("pre_rst_busy", {31'd0, eng_busy}, 32'd1);
    check("pre_rst_rd_valid", {31'd0, eng_rd_valid}, 32'd1);
    #2 rst = 1;
    #1;
    check("arst_bank_sel", {31'd0, bank_sel}, 32'd0);
    check("arst_host_ready", {31'd0, host_ready}, 32'd0);
    check("arst_eng_busy", {31'd0, eng_busy}, 32'd0);
    check("arst_eng_rd_valid", {31'd0, eng_rd_valid}, 32'd0);
    check("arst_eng_rd_data", eng_rd_data, 32'd0);
    check("arst_host_rdata", host_rdata, 32'd0);
    check("arst_err_overrun", {31'd0, err_overrun}, 32'd0);
    check("arst_err_wrlock", {31'd0, err_wrlock}, 32'd0);
    check("arst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    tick();
    rst = 0;
    tick();
    host_read(5);
    check("post_rst_host5", host_rdata, 32'hABCD_1234);
    host_read(7);
    check("post_rst_host7", host_rdata, 32'h00FF_00FF);
    eng_read(5);
    check("post_rst_eng5", eng_rd_data, 32'h4444_3333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_pingpong_ram.md
# fft_pingpong_ram

Double-buffered complex sample memory for the FFT datapath. It holds two banks of `DEPTH` complex words. The host (AXI-side) loads one bank while the FFT engine transforms the other in place. Bank ownership swaps under a done/start handshake. This block replaces the single-bank, mode-switched RAM with parametrised widths, per-half host writes, engine read/write in the same cycle, frame sequencing and error flags.

## Interface
Parameters:
- `DATA_W`, default 16: width of one real or imaginary component. A memory word is 2*DATA_W bits, with imag in the upper half and real in the lower half.
- `ADDR_W`, default 12: word address width. DEPTH = 2**ADDR_W words per bank.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `host_wr` in 1: host write strobe.
- `host_rd` in 1: host read strobe.
- `host_addr` in ADDR_W+1: bits [ADDR_W:1] are the word address; bit 0 selects the half for writes (0 = real, 1 = imag).
- `host_wdata` in DATA_W: host write data.
- `host_rdata` out 2*DATA_W: full word read from the host bank.
- `host_rvalid` out 1: pulse; `host_rdata` is valid.
- `host_done` in 1: pulse; the host bank is loaded and committed.
- `eng_rd_en` in 1: engine read strobe.
- `eng_rd_addr` in ADDR_W: engine read address.
- `eng_rd_data` out 2*DATA_W: engine read data.
- `eng_rd_valid` out 1: pulse; `eng_rd_data` is valid.
- `eng_wr_en` in 1: engine write strobe.
- `eng_wr_addr` in ADDR_W: engine write address.
- `eng_wr_data` in 2*DATA_W: engine write data (full word).
- `eng_done` in 1: pulse; the engine has finished the current frame.
- `eng_start` out 1: pulse; a new frame is available in the engine bank.
- `bank_sel` out 1: bank currently owned by the host. The engine owns !bank_sel.
- `host_ready` out 1: the host bank is committed and waiting for a swap.
- `eng_busy` out 1: the engine is processing a frame.
- `frame_cnt` out 8: number of completed swaps; wraps 255->0.
- `err_overrun` out 1: sticky; set by `host_done` while `host_ready`=1.
- `err_wrlock` out 1: sticky; set by `host_wr` while `host_ready`=1.

## Operation
- Storage: two banks, each DEPTH x 2*DATA_W. Contents are not reset.
- Host port addresses bank `bank_sel` only. Engine ports address bank !`bank_sel` only.
- Host write:
  - Writes `host_wdata` into the selected half of the word. The other half is preserved.
  - Is dropped when `host_ready`=1; `err_wrlock` is set instead.
- Host read: returns the full word. It is valid when `host_wr`=0. When `host_wr` and `host_rd` are both high, the write takes priority and there is no read and no `host_rvalid`.
- Engine:
  - Read and write are independent and may occur in the same cycle.
  - A same-address read and write returns the old data (read-first).
  - Engine accesses are honoured regardless of `eng_busy`.
- Handshake flags:
  - `host_done` sets `host_ready`.
  - `host_done` while `host_ready`=1 is ignored and sets `err_overrun`.
  - `eng_done` clears `eng_busy`. `eng_done` while `eng_busy`=0 is ignored.
- Swap condition: registered `host_ready`=1 and registered `eng_busy`=0. On the swap edge, in one cycle:
  - `bank_sel` toggles;
  - `host_ready` clears;
  - `eng_busy` sets;
  - `eng_start` pulses for 1 cycle;
  - `frame_cnt` increments.
- After a swap, the host bank holds the previous frame's in-place results. The host reads them before overwriting.
- Error flags are cleared only by `rst`.

## Timing
- Reset values: `bank_sel`=0, `host_ready`=0, `eng_busy`=0, `eng_start`=0, `frame_cnt`=0, both error flags 0, `host_rvalid`=0, `eng_rd_valid`=0, `host_rdata`=0, `eng_rd_data`=0.
- Read latency is 1 cycle on both ports. A strobe at edge N gives data and valid from edge N+1 for one cycle. Data holds its value until the next read.
- Writes take effect at the strobe edge. A read of the same location issued in the following cycle sees the new data.
- `host_done` sampled at edge N:
  - `host_ready`=1 after N.
  - If `eng_busy`=0, the swap happens at edge N+1. `eng_start` and the new `bank_sel` are visible after N+1.
- `eng_done` and `host_done` in the same cycle while `eng_busy`=1 and `host_ready`=0: both flags update at that edge, and the swap happens at the next edge.
- A read in flight across a swap edge returns data from the bank that was selected at the strobe edge.
- Asserting `rst` mid-frame:
  - All flags and outputs return to reset values immediately.
  - Any in-flight read valid is dropped.
  - Memory retains its contents.

## Test plan
- Reset, then host writes real=0x1234 and imag=0xABCD to word 5. Host read of word 5 -> `host_rdata`=0xABCD1234 with `host_rvalid` one cycle later.
- `host_done` at cycle 10 -> `host_ready`=1 at 11. Swap at 12: `bank_sel`=1, `eng_start` 1-cycle pulse, `frame_cnt`=1. Engine read of word 5 -> 0xABCD1234.
- Engine read and write to word 7 in the same cycle with data 0x00FF00FF -> read returns the old value. A read the next cycle returns 0x00FF00FF.
- With `eng_busy`=1, `host_done` twice -> `err_overrun`=1. A `host_wr` while `host_ready` -> `err_wrlock`=1 and memory unchanged. No swap occurs until `eng_done`; the swap follows one edge after `eng_done`.
- Run 256 full frames -> `frame_cnt` wraps to 0, and `bank_sel` alternates each frame. The host sees the engine-written results of frame k after swap k+1.
- Assert `rst` while `eng_busy`=1 and `host_ready`=1 -> all outputs go to reset values asynchronously, and previously written words read back unchanged afterward.
